clk_div_sched: RTL
==================

Name: clk_div_sched

Overview:
- Runtime-controlled clock-divider scheduler for the DE1 50 MHz domain. It replaces several fixed dividers with one shared counter.
- The divisor is chosen from four parameterized presets, either through a req/ack configuration handshake or by an auto-sequencer that cycles through the presets.
- Divisor changes apply only on a period boundary, so o_clk has no runt pulses.
- Outputs drive LEDG blink logic and tick-enabled consumers.

Parameters:
- CNT_W, 26, counter width; must hold PRESETn-1.
- PRESET0, 2, divisor for sel 0.
- PRESET1, 10, divisor for sel 1.
- PRESET2, 1000000, divisor for sel 2.
- PRESET3, 50000000, divisor for sel 3.
- DWELL, 4, number of completed periods per preset in auto mode (>=1).

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = count, 0 = hold idle.
- auto_en  in  1  1 = auto-sequence presets.
- cfg_req  in  1  configuration request; held high until cfg_ack.
- cfg_sel  in  2  requested preset index; stable while cfg_req is high.
- cfg_ack  out  1  one-cycle pulse when the requested preset takes effect.
- o_clk  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on the last count of each period.
- cur_sel  out  2  preset currently in effect.
- pending  out  1  a configuration change is latched and waiting for the boundary.

Behaviour:
- Reset (async, rst=1): cnt=0, cur_sel=0, pend_sel=0, pending=0, dwell_cnt=0, o_clk=0, tick=0, cfg_ack=0.
- div = PRESET[cur_sel]; any value below 2 is clamped to 2. half = div>>1.
- States:
  - IDLE (run=0): cnt, o_clk and tick held at 0. cfg_req still accepted; the change applies immediately (cur_sel<=cfg_sel) and cfg_ack pulses the next cycle. dwell_cnt is cleared.
  - RUN (run=1, pending=0): cnt counts 0..div-1, then wraps to 0.
  - PEND (run=1, pending=1): counting continues with the old div until the boundary.
- Transitions:
  - IDLE->RUN when run rises. The first period starts at cnt=0.
  - RUN->IDLE immediately when run falls, mid-period included. Outputs go to 0 the next cycle and any pending change applies at once, with ack.
- Outputs:
  - o_clk is registered and equals (cnt >= half) for the current cnt: low for half cycles, high for div-half cycles. Odd div gives the longer high phase; div=5 is 2 low, 3 high.
  - tick = run && cnt==div-1; no extra latency beyond the cnt register.
- Config handshake:
  - A cfg_req seen with pending=0 latches pend_sel=cfg_sel and sets pending the next cycle.
  - At the boundary (tick cycle) the next cycle gets cur_sel=pend_sel, pending=0, cnt=0 with the new div, and cfg_ack=1 for exactly one cycle.
  - The requester drops cfg_req after ack. A cfg_req still high in the ack cycle is not re-accepted; a new request needs a low cycle first.
  - A request for the same sel as cur_sel still completes at the boundary with ack; no period disturbance.
- Auto mode (auto_en=1, no pending):
  - dwell_cnt increments on each tick.
  - On the tick where dwell_cnt==DWELL-1, cur_sel advances by 1 (3 wraps to 0) at the boundary and dwell_cnt clears. No cfg_ack is issued.
- Simultaneous events:
  - A pending manual request wins over an auto advance at the same boundary. dwell_cnt clears and the auto sequence resumes from the new cur_sel.
  - A cfg_req arriving in the boundary cycle itself is latched and applied at the next boundary.
- auto_en falling clears dwell_cnt; cur_sel stays as is.
- Reset mid-operation aborts any pending request. No cfg_ack is issued; the requester must re-request.
- Widths: cnt is CNT_W bits; comparisons are unsigned. No overflow is possible because PRESETn <= 2^CNT_W.

Test Plan (bench overrides PRESET0..3 = 2, 5, 10, 16; DWELL = 2):
- Reset then run=1 with sel 0: o_clk alternates 0,1 every cycle and tick fires every 2nd cycle. Then select sel 2: o_clk is 5 low / 5 high and tick fires every 10 cycles.
- Odd divisor: cfg sel 1 -> cfg_ack pulses once, then o_clk repeats 0,0,1,1,1 and tick is high on the 5th cycle of each period.
- Mid-period change: running sel 2, cfg_req sel 3 at cnt=3 -> pending=1, and cnt continues to 9 with tick. cfg_ack, cur_sel=3 and cnt=0 appear together; next periods are 8 low / 8 high. The o_clk high phase of the old period has its full length of 5.
- Auto mode from sel 0: cur_sel steps 0->1->2->3->0 after every 2 ticks, with cfg_ack never asserted. A manual cfg_req sel 2 issued during the second dwell period applies at that boundary instead of the auto step, and ack fires.
- run falls at cnt=6 with a pending sel 0 request: the next cycle has o_clk=0, tick=0, cnt=0, cur_sel=0 and a single cfg_ack. run rises again and a clean period-2 output follows.
- rst asserted asynchronously mid-period with pending=1: all outputs drop to 0 without waiting for clk, pending=0, cur_sel=0, and no ack follows after release.

Source files
------------

// File: rtl/clk_div_sched_if.sv
// Control and status bundle for the clock-divider scheduler.
// The master drives run/auto/config; the slave returns the divided clock and status.
interface clk_div_sched_if;
  logic       run;
  logic       auto_en;
  logic       cfg_req;
  logic [1:0] cfg_sel;
  logic       cfg_ack;
  logic       o_clk;
  logic       tick;
  logic [1:0] cur_sel;
  logic       pending;

  modport master (
    output run, auto_en, cfg_req, cfg_sel,
    input  cfg_ack, o_clk, tick, cur_sel, pending
  );

  modport slave (
    input  run, auto_en, cfg_req, cfg_sel,
    output cfg_ack, o_clk, tick, cur_sel, pending
  );
endinterface

// File: rtl/clk_div_sched.sv
// Shared-counter clock divider with four selectable presets, a req/ack config handshake
// and an auto-sequencer; divisor changes land only on a period boundary.
module clk_div_sched #(
  parameter int unsigned CNT_W   = 26,
  parameter int unsigned PRESET0 = 2,
  parameter int unsigned PRESET1 = 10,
  parameter int unsigned PRESET2 = 1000000,
  parameter int unsigned PRESET3 = 50000000,
  parameter int unsigned DWELL   = 4
) (
  input logic             clk,
  input logic             rst,
  clk_div_sched_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);

  function automatic logic [CNT_W-1:0] clamp_div(input int unsigned p);
    return (p < 2) ? CNT_W'(2) : CNT_W'(p);
  endfunction

  localparam logic [CNT_W-1:0] Div0 = clamp_div(PRESET0);
  localparam logic [CNT_W-1:0] Div1 = clamp_div(PRESET1);
  localparam logic [CNT_W-1:0] Div2 = clamp_div(PRESET2);
  localparam logic [CNT_W-1:0] Div3 = clamp_div(PRESET3);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cur_sel_q, cur_sel_d;
  logic [1:0]        pend_sel_q, pend_sel_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              o_clk_q, o_clk_d;
  logic              ack_q, ack_d;
  logic              lock_q, lock_d;

  logic [CNT_W-1:0]  div, half;
  logic              last_cnt, accept;

  always_comb begin
    div = Div0;
    case (cur_sel_q)
      2'd0:    div = Div0;
      2'd1:    div = Div1;
      2'd2:    div = Div2;
      default: div = Div3;
    endcase
  end

  assign half     = div >> 1;
  assign last_cnt = (cnt_q == div - CNT_W'(1));
  // lock_q blocks a still-high cfg_req from being taken twice; it clears once req drops.
  assign accept   = bus.cfg_req && !lock_q && (state_q != StPend);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    dwell_d    = dwell_q;
    ack_d      = 1'b0;
    lock_d     = bus.cfg_req & (lock_q | accept);

    if (!bus.run) begin
      state_d = StIdle;
      cnt_d   = '0;
      dwell_d = '0;
      if (state_q == StPend) begin
        cur_sel_d = pend_sel_q;
        ack_d     = 1'b1;
      end else if (accept) begin
        cur_sel_d = bus.cfg_sel;
        ack_d     = 1'b1;
      end
    end else begin
      cnt_d = last_cnt ? '0 : cnt_q + CNT_W'(1);
      if (!bus.auto_en) dwell_d = '0;
      unique case (state_q)
        StPend: begin
          if (last_cnt) begin
            cur_sel_d = pend_sel_q;
            ack_d     = 1'b1;
            dwell_d   = '0;
            state_d   = StRun;
          end
        end
        default: begin
          state_d = StRun;
          if (bus.auto_en && last_cnt) begin
            if (dwell_q == DwellLast) begin
              cur_sel_d = cur_sel_q + 2'd1;
              dwell_d   = '0;
            end else begin
              dwell_d = dwell_q + DwellW'(1);
            end
          end
          if (accept) begin
            pend_sel_d = bus.cfg_sel;
            state_d    = StPend;
          end
        end
      endcase
    end

    // cnt_d is zero whenever the divisor changes, so the current half is always safe here.
    o_clk_d = (cnt_d >= half);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cur_sel_q  <= 2'd0;
      pend_sel_q <= 2'd0;
      dwell_q    <= '0;
      o_clk_q    <= 1'b0;
      ack_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      dwell_q    <= dwell_d;
      o_clk_q    <= o_clk_d;
      ack_q      <= ack_d;
      lock_q     <= lock_d;
    end
  end

  assign bus.o_clk   = o_clk_q;
  assign bus.tick    = bus.run && last_cnt;
  assign bus.cfg_ack = ack_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.pending = (state_q == StPend);

endmodule
